// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-ported register file with write-port priority, a busy
// scoreboard for hazard detection and a registered write-collision flag.
// Optional macro REG_FILE_BYPASS_EN adds same-cycle write-to-read forwarding
// of data and busy status; without it reads come from stored state only.
module reg_file_mp #(
    parameter int WIDTH  = 16,
    parameter int N_REGS = 8,
    parameter int N_RD   = 2,
    parameter int N_WR   = 2,
    parameter int AW     = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_WR-1:0]         i_wr_en,
    input  logic [N_WR*AW-1:0]      i_wr_addr,
    input  logic [N_WR*WIDTH-1:0]   i_wr_data,
    input  logic [N_RD*AW-1:0]      i_rd_addr,
    output logic [N_RD*WIDTH-1:0]   o_rd_data,
    input  logic                    i_rsv_en,
    input  logic [AW-1:0]           i_rsv_addr,
    output logic [N_REGS-1:0]       o_busy,
    output logic [N_RD-1:0]         o_rd_busy,
    output logic                    o_wr_conflict
);

    logic [WIDTH-1:0]      r_mem [N_REGS];
    logic [N_REGS-1:0]     r_busy;
    logic                  r_wr_conflict;

    logic [N_REGS-1:0]     w_busy_nxt;
    logic                  w_conflict;
    logic [N_RD*WIDTH-1:0] w_rd_data;
    logic [N_RD-1:0]       w_rd_busy;

    // Address decode guard; only matters when N_REGS is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] a);
        return (32'(a) < N_REGS);
    endfunction

    // Detect two or more enabled in-range write ports aiming at one register.
    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < N_WR; i++) begin
            for (int k = i + 1; k < N_WR; k++) begin
                if (i_wr_en[i] && i_wr_en[k] &&
                    in_range(i_wr_addr[i*AW +: AW]) &&
                    (i_wr_addr[i*AW +: AW] == i_wr_addr[k*AW +: AW]))
                    w_conflict = 1'b1;
            end
        end
    end

    // Next scoreboard: writes retire producers, then a reserve re-marks busy
    // so a freshly issued producer wins over a same-cycle writeback.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int k = 0; k < N_WR; k++) begin
            if (i_wr_en[k] && in_range(i_wr_addr[k*AW +: AW]))
                w_busy_nxt[i_wr_addr[k*AW +: AW]] = 1'b0;
        end
        if (i_rsv_en && in_range(i_rsv_addr))
            w_busy_nxt[i_rsv_addr] = 1'b1;
    end

    // Array update; later ports overwrite earlier ones, giving the highest
    // enabled port priority on a collision.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < N_REGS; r++)
                r_mem[r] <= '0;
        end else begin
            for (int k = 0; k < N_WR; k++) begin
                if (i_wr_en[k] && in_range(i_wr_addr[k*AW +: AW]))
                    r_mem[i_wr_addr[k*AW +: AW]] <= i_wr_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Scoreboard and collision flag registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy        <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            r_busy        <= w_busy_nxt;
            r_wr_conflict <= w_conflict;
        end
    end

    // Read ports: stored state, optionally overridden by same-cycle writes.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int j = 0; j < N_RD; j++) begin
            if (in_range(i_rd_addr[j*AW +: AW])) begin
                w_rd_data[j*WIDTH +: WIDTH] = r_mem[i_rd_addr[j*AW +: AW]];
                w_rd_busy[j]                = r_busy[i_rd_addr[j*AW +: AW]];
`ifdef REG_FILE_BYPASS_EN
                if (!i_rst) begin
                    for (int k = 0; k < N_WR; k++) begin
                        if (i_wr_en[k] &&
                            (i_wr_addr[k*AW +: AW] == i_rd_addr[j*AW +: AW])) begin
                            w_rd_data[j*WIDTH +: WIDTH] = i_wr_data[k*WIDTH +: WIDTH];
                            if (!(i_rsv_en && (i_rsv_addr == i_rd_addr[j*AW +: AW])))
                                w_rd_busy[j] = 1'b0;
                        end
                    end
                end
`endif
            end
        end
    end

    assign o_rd_data     = w_rd_data;
    assign o_rd_busy     = w_rd_busy;
    assign o_busy        = r_busy;
    assign o_wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp; expectations are queued as stimulus is
// applied and checked against the DUT outputs once they are due.
module tb_reg_file_mp;

    localparam int WIDTH  = 16;
    localparam int N_REGS = 8;
    localparam int N_RD   = 2;
    localparam int N_WR   = 2;
    localparam int AW     = 3;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic [N_WR-1:0]       wr_en;
    logic [N_WR*AW-1:0]    wr_addr;
    logic [N_WR*WIDTH-1:0] wr_data;
    logic [N_RD*AW-1:0]    rd_addr;
    logic [N_RD*WIDTH-1:0] rd_data;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;
    logic [N_REGS-1:0]     busy;
    logic [N_RD-1:0]       rd_busy;
    logic                  wr_conflict;

    reg_file_mp #(.WIDTH(WIDTH), .N_REGS(N_REGS), .N_RD(N_RD), .N_WR(N_WR)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .i_rsv_en     (rsv_en),
        .i_rsv_addr   (rsv_addr),
        .o_busy       (busy),
        .o_rd_busy    (rd_busy),
        .o_wr_conflict(wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 rd_data, 1 rd_busy, 2 busy, 3 wr_conflict
        int          idx;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(input int kind, input int idx);
        case (kind)
            0:       return 32'(rd_data[idx*WIDTH +: WIDTH]);
            1:       return 32'(rd_busy[idx]);
            2:       return 32'(busy);
            default: return 32'(wr_conflict);
        endcase
    endfunction

    task automatic push(input int kind, input int idx, input logic [31:0] v, input string tag);
        exp_t e;
        e.kind = kind; e.idx = idx; e.exp = v; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic exp_rd(input int j, input logic [31:0] v, input string tag);
        push(0, j, v, tag);
    endtask
    task automatic exp_rdb(input int j, input logic [31:0] v, input string tag);
        push(1, j, v, tag);
    endtask
    task automatic exp_busy(input logic [31:0] v, input string tag);
        push(2, 0, v, tag);
    endtask
    task automatic exp_conf(input logic [31:0] v, input string tag);
        push(3, 0, v, tag);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] obs;
        #1;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = observe(e.kind, e.idx);
            checks++;
            assert (obs === e.exp)
            else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic set_wr(input logic [1:0] en, input int a0, input logic [15:0] d0,
                          input int a1, input logic [15:0] d1);
        wr_en   = en;
        wr_addr = {AW'(a1), AW'(a0)};
        wr_data = {d1, d0};
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    initial begin
        rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; rsv_en = 1'b0; rsv_addr = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state across all registers
        for (int r = 0; r < N_REGS; r += 2) begin
            set_rd(r, r + 1);
            exp_rd(0, 0, "rst_rd0"); exp_rd(1, 0, "rst_rd1");
            exp_rdb(0, 0, "rst_rdb0"); exp_rdb(1, 0, "rst_rdb1");
            drain();
        end
        exp_busy(0, "rst_busy"); exp_conf(0, "rst_conf");
        drain();

        // Dual write to distinct registers
        set_wr(2'b11, 3, 16'h1234, 5, 16'hBEEF);
        tick(); idle();
        set_rd(3, 5);
        exp_rd(0, 16'h1234, "dual_r3"); exp_rd(1, 16'hBEEF, "dual_r5");
        exp_conf(0, "dual_conf");
        drain();

        // Collision: higher port wins, flag lasts one cycle
        set_wr(2'b11, 2, 16'h1111, 2, 16'h2222);
        tick(); idle();
        set_rd(2, 2);
        exp_rd(0, 16'h2222, "coll_rd0"); exp_rd(1, 16'h2222, "coll_rd1");
        exp_conf(1, "coll_conf_hi");
        drain();
        tick();
        exp_conf(0, "coll_conf_lo"); exp_rd(0, 16'h2222, "coll_hold");
        drain();

        // Reserve r4
        rsv_en = 1'b1; rsv_addr = 3'd4;
        tick(); idle();
        set_rd(4, 3);
        exp_busy(8'h10, "rsv_busy"); exp_rdb(0, 1, "rsv_rdb0"); exp_rdb(1, 0, "rsv_rdb1");
        drain();

        // Writeback to r4 clears it
        set_wr(2'b10, 0, 16'h0000, 4, 16'h00AA);
        tick(); idle();
        exp_busy(0, "clr_busy"); exp_rd(0, 16'h00AA, "clr_rd"); exp_rdb(0, 0, "clr_rdb");
        drain();

        // Reserve and write r6 together: reserve wins
        rsv_en = 1'b1; rsv_addr = 3'd6;
        set_wr(2'b01, 6, 16'h0606, 0, 16'h0000);
        tick(); idle();
        set_rd(6, 6);
        exp_busy(8'h40, "rw_busy"); exp_rd(0, 16'h0606, "rw_rd"); exp_rdb(1, 1, "rw_rdb");
        drain();

        // Re-reserving a busy register keeps it busy
        rsv_en = 1'b1; rsv_addr = 3'd6;
        tick(); idle();
        exp_busy(8'h40, "rerv_busy");
        drain();

        // Preload r1 = 0x0007
        set_wr(2'b01, 1, 16'h0007, 0, 16'h0000);
        tick(); idle();

        // Same-cycle write/read of r1, plus writeback of busy r6
        set_wr(2'b11, 1, 16'h5A5A, 6, 16'h6666);
        set_rd(1, 6);
        exp_rd(0, BYP ? 32'h5A5A : 32'h0007, "byp_rd0");
        exp_rd(1, BYP ? 32'h6666 : 32'h0606, "byp_rd1");
        exp_rdb(1, BYP ? 32'd0 : 32'd1, "byp_rdb1");
        drain();
        tick(); idle();
        exp_rd(0, 16'h5A5A, "post_rd0"); exp_rd(1, 16'h6666, "post_rd1");
        exp_busy(0, "post_busy"); exp_conf(0, "post_conf");
        drain();

        // Preload r7, then reset with colliding writes and a reserve on r7
        set_wr(2'b01, 7, 16'h7777, 0, 16'h0000);
        tick(); idle();
        rst = 1'b1;
        set_wr(2'b11, 7, 16'hFFFF, 7, 16'hFFFF);
        rsv_en = 1'b1; rsv_addr = 3'd7;
        set_rd(7, 5);
        exp_rd(0, 16'h7777, "rstw_nobyp");
        drain();
        tick();
        rst = 1'b0; idle();
        set_rd(7, 3);
        exp_rd(0, 0, "mrst_r7"); exp_rd(1, 0, "mrst_r3");
        exp_busy(0, "mrst_busy"); exp_conf(0, "mrst_conf");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
